// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the drink vending controller
package vend_pkg;

    localparam int CASH_W      = 7;
    localparam int TIMEOUT_CYC = 1024;

    localparam logic [CASH_W-1:0] COFFEE_PRICE = CASH_W'(50);
    localparam logic [CASH_W-1:0] TEA_PRICE    = CASH_W'(35);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        DISPENSE,
        CHANGE,
        REFUND
    } state_t;

    typedef enum logic {
        COFFEE = 1'b0,
        TEA    = 1'b1
    } drink_t;

    function automatic logic [CASH_W-1:0] price_of(drink_t d);
        return (d == TEA) ? TEA_PRICE : COFFEE_PRICE;
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// vend_credit_acc: credit register that refuses coins which would overflow it
module vend_credit_acc
    import vend_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add_en,
    input  logic              clr,
    input  logic              rej_req,
    input  logic [CASH_W-1:0] coin_val,
    output logic [CASH_W-1:0] credit,
    output logic              coin_reject
);

    logic [CASH_W:0] sum;

    assign sum = {1'b0, credit} + {1'b0, coin_val};

    // Accept the coin only if the sum fits; an overflowing coin is handed back untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= rej_req | (add_en & sum[CASH_W]);
            credit      <= clr ? '0 : (add_en && !sum[CASH_W]) ? sum[CASH_W-1:0] : credit;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending sequencer (collect, check, dispense, change/refund); VEND_TIMEOUT_EN adds idle auto-refund
module vend_ctrl
    import vend_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin_valid,
    input  logic [CASH_W-1:0] coin_val,
    input  logic              sel_valid,
    input  logic              sel_drink,
    input  logic              cancel,
    input  logic              disp_done,
    input  logic              change_ack,
    output logic              coffee_en,
    output logic              tea_en,
    output logic              cash_low,
    output logic              coin_reject,
    output logic              change_valid,
    output logic [CASH_W-1:0] change_amt,
    output logic [CASH_W-1:0] credit
);

    state_t            state, nxt;
    drink_t            drink;
    logic              add_en, rej_req, clr, low_nxt, timeout;
    logic [CASH_W-1:0] price;

    assign price = price_of(drink);

    vend_credit_acc u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .add_en     (add_en),
        .clr        (clr),
        .rej_req    (rej_req),
        .coin_val   (coin_val),
        .credit     (credit),
        .coin_reject(coin_reject)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] idle_cnt;

    assign timeout = (state == COLLECT) && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Count idle COLLECT cycles; any coin or selection restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt <= '0;
        else        idle_cnt <= (state == COLLECT && !coin_valid && !sel_valid) ? idle_cnt + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and credit-control decode
    always_comb begin
        nxt     = state;
        add_en  = 1'b0;
        rej_req = 1'b0;
        clr     = 1'b0;
        low_nxt = 1'b0;
        case (state)
            IDLE: begin
                add_en  = coin_valid;
                nxt     = coin_valid ? (sel_valid ? CHECK : COLLECT) : IDLE;
                low_nxt = sel_valid && !coin_valid;
            end
            COLLECT: begin
                add_en  = coin_valid && !cancel;
                rej_req = coin_valid && cancel;
                nxt     = cancel ? REFUND : sel_valid ? CHECK : (timeout && !coin_valid) ? REFUND : COLLECT;
            end
            CHECK: begin
                rej_req = coin_valid;
                nxt     = (credit >= price) ? DISPENSE : COLLECT;
                low_nxt = credit < price;
            end
            DISPENSE: begin
                rej_req = coin_valid;
                nxt     = disp_done ? ((change_amt != '0) ? CHANGE : IDLE) : DISPENSE;
                clr     = disp_done && (change_amt == '0);
            end
            CHANGE, REFUND: begin
                rej_req = coin_valid;
                nxt     = change_ack ? IDLE : state;
                clr     = change_ack;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Registered outputs, derived from the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drink        <= COFFEE;
            coffee_en    <= 1'b0;
            tea_en       <= 1'b0;
            cash_low     <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
        end else begin
            drink        <= (nxt == CHECK) ? drink_t'(sel_drink) : drink;
            coffee_en    <= (nxt == DISPENSE) && (drink == COFFEE);
            tea_en       <= (nxt == DISPENSE) && (drink == TEA);
            cash_low     <= low_nxt;
            change_valid <= (nxt == CHANGE) || (nxt == REFUND);
            change_amt   <= (state == CHECK && nxt == DISPENSE) ? credit - price :
                            (state == COLLECT && nxt == REFUND) ? credit :
                            clr ? '0 : change_amt;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed vector table plus reset and idle-timeout sequences for vend_ctrl
module tb_vend_ctrl;
    import vend_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              coin_valid = 1'b0;
    logic [CASH_W-1:0] coin_val = '0;
    logic              sel_valid = 1'b0;
    logic              sel_drink = 1'b0;
    logic              cancel = 1'b0;
    logic              disp_done = 1'b0;
    logic              change_ack = 1'b0;
    logic              coffee_en, tea_en, cash_low, coin_reject, change_valid;
    logic [CASH_W-1:0] change_amt, credit;

    vend_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .sel_valid   (sel_valid),
        .sel_drink   (sel_drink),
        .cancel      (cancel),
        .disp_done   (disp_done),
        .change_ack  (change_ack),
        .coffee_en   (coffee_en),
        .tea_en      (tea_en),
        .cash_low    (cash_low),
        .coin_reject (coin_reject),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .credit      (credit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              cv;
        logic [CASH_W-1:0] cval;
        logic              sv, sd, cn, dd, ca;
    } in_t;

    typedef struct packed {
        logic              ce, te, cl, cr, chv;
        logic [CASH_W-1:0] amt, cred;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    int applied = 0;
    int errs = 0;
    vec_t tbl[$];

    function automatic in_t mi(bit cv, int cval, bit sv, bit sd, bit cn, bit dd, bit ca);
        in_t r;
        r.cv = cv; r.cval = CASH_W'(cval); r.sv = sv; r.sd = sd; r.cn = cn; r.dd = dd; r.ca = ca;
        return r;
    endfunction

    function automatic out_t mo(bit ce, bit te, bit cl, bit cr, bit chv, int amt, int cred);
        out_t r;
        r.ce = ce; r.te = te; r.cl = cl; r.cr = cr; r.chv = chv;
        r.amt = CASH_W'(amt); r.cred = CASH_W'(cred);
        return r;
    endfunction

    function automatic out_t sample();
        return mo(coffee_en, tea_en, cash_low, coin_reject, change_valid, int'(change_amt), int'(credit));
    endfunction

    task automatic drive(in_t i);
        coin_valid = i.cv; coin_val = i.cval; sel_valid = i.sv; sel_drink = i.sd;
        cancel = i.cn; disp_done = i.dd; change_ack = i.ca;
    endtask

    task automatic check(string nm, out_t e);
        out_t a;
        a = sample();
        applied++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got ce=%0b te=%0b low=%0b rej=%0b chv=%0b amt=%0d cred=%0d, want ce=%0b te=%0b low=%0b rej=%0b chv=%0b amt=%0d cred=%0d",
                     nm, a.ce, a.te, a.cl, a.cr, a.chv, a.amt, a.cred, e.ce, e.te, e.cl, e.cr, e.chv, e.amt, e.cred);
        end
    endtask

    task automatic check_int(string nm, int a, int e);
        applied++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    task automatic step(string nm, in_t i, out_t e);
        @(negedge clk);
        drive(i);
        @(posedge clk);
        #1;
        check(nm, e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1: 20+20+10, coffee exact
        tbl.push_back('{mi(1,20,0,0,0,0,0), mo(0,0,0,0,0, 0,20)});
        tbl.push_back('{mi(1,20,0,0,0,0,0), mo(0,0,0,0,0, 0,40)});
        tbl.push_back('{mi(1,10,0,0,0,0,0), mo(0,0,0,0,0, 0,50)});
        tbl.push_back('{mi(0, 0,1,0,0,0,0), mo(0,0,0,0,0, 0,50)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(1,0,0,0,0, 0,50)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(1,0,0,0,0, 0,50)});
        tbl.push_back('{mi(0, 0,0,0,0,1,0), mo(0,0,0,0,0, 0, 0)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,0,0,0,0, 0, 0)});
        // 2: 50, tea, change 15
        tbl.push_back('{mi(1,50,0,0,0,0,0), mo(0,0,0,0,0, 0,50)});
        tbl.push_back('{mi(0, 0,1,1,0,0,0), mo(0,0,0,0,0, 0,50)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,1,0,0,0,15,50)});
        tbl.push_back('{mi(0, 0,0,0,0,1,0), mo(0,0,0,0,1,15,50)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,0,0,0,1,15,50)});
        tbl.push_back('{mi(0, 0,0,0,0,0,1), mo(0,0,0,0,0, 0, 0)});
        // 3: short credit, top up, change 10
        tbl.push_back('{mi(1,20,0,0,0,0,0), mo(0,0,0,0,0, 0,20)});
        tbl.push_back('{mi(0, 0,1,0,0,0,0), mo(0,0,0,0,0, 0,20)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,0,1,0,0, 0,20)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,0,0,0,0, 0,20)});
        tbl.push_back('{mi(1,40,0,0,0,0,0), mo(0,0,0,0,0, 0,60)});
        tbl.push_back('{mi(0, 0,1,0,0,0,0), mo(0,0,0,0,0, 0,60)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(1,0,0,0,0,10,60)});
        tbl.push_back('{mi(0, 0,0,0,0,1,0), mo(0,0,0,0,1,10,60)});
        tbl.push_back('{mi(0, 0,0,0,0,0,1), mo(0,0,0,0,0, 0, 0)});
        // 4: overflow reject, cancel refund; ack on entry cycle is ignored
        tbl.push_back('{mi(1,100,0,0,0,0,0), mo(0,0,0,0,0,  0,100)});
        tbl.push_back('{mi(1, 50,0,0,0,0,0), mo(0,0,0,1,0,  0,100)});
        tbl.push_back('{mi(0,  0,0,0,1,0,1), mo(0,0,0,0,1,100,100)});
        tbl.push_back('{mi(0,  0,0,0,0,0,1), mo(0,0,0,0,0,  0,  0)});
        // 5: sel and cancel together -> refund
        tbl.push_back('{mi(1,30,0,0,0,0,0), mo(0,0,0,0,0, 0,30)});
        tbl.push_back('{mi(0, 0,1,0,1,0,0), mo(0,0,0,0,1,30,30)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,0,0,0,1,30,30)});
        tbl.push_back('{mi(0, 0,0,0,0,0,1), mo(0,0,0,0,0, 0, 0)});
        // sel with no credit; coin+sel in IDLE; coin, ack and done outside their states
        tbl.push_back('{mi(0, 0,1,1,0,0,0), mo(0,0,1,0,0, 0, 0)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,0,0,0,0, 0, 0)});
        tbl.push_back('{mi(1,35,1,1,0,0,0), mo(0,0,0,0,0, 0,35)});
        tbl.push_back('{mi(0, 0,0,0,0,0,0), mo(0,1,0,0,0, 0,35)});
        tbl.push_back('{mi(1,10,0,0,0,0,0), mo(0,1,0,1,0, 0,35)});
        tbl.push_back('{mi(0, 0,1,0,1,0,1), mo(0,1,0,0,0, 0,35)});
        tbl.push_back('{mi(0, 0,0,0,0,1,0), mo(0,0,0,0,0, 0, 0)});
        tbl.push_back('{mi(0, 0,0,0,0,1,0), mo(0,0,0,0,0, 0, 0)});
        // coin with cancel is rejected, refund keeps prior credit
        tbl.push_back('{mi(1,25,0,0,0,0,0), mo(0,0,0,0,0, 0,25)});
        tbl.push_back('{mi(1,10,0,0,1,0,0), mo(0,0,0,1,1,25,25)});
        tbl.push_back('{mi(0, 0,0,0,0,0,1), mo(0,0,0,0,0, 0, 0)});
        // saturation boundary: 127 fits, one more does not
        tbl.push_back('{mi(1,100,0,0,0,0,0), mo(0,0,0,0,0,  0,100)});
        tbl.push_back('{mi(1, 27,0,0,0,0,0), mo(0,0,0,0,0,  0,127)});
        tbl.push_back('{mi(1,  1,0,0,0,0,0), mo(0,0,0,1,0,  0,127)});
        tbl.push_back('{mi(0,  0,0,0,1,0,0), mo(0,0,0,0,1,127,127)});
        tbl.push_back('{mi(0,  0,0,0,0,0,1), mo(0,0,0,0,0,  0,  0)});

        repeat (2) @(posedge clk);
        #1;
        check("reset", mo(0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

        // async reset during dispense
        step("rd_coin", mi(1,50,0,0,0,0,0), mo(0,0,0,0,0, 0,50));
        step("rd_sel",  mi(0, 0,1,1,0,0,0), mo(0,0,0,0,0, 0,50));
        step("rd_disp", mi(0, 0,0,0,0,0,0), mo(0,1,0,0,0,15,50));
        #2;
        rst_n = 1'b0;
        #1;
        check("rd_async", mo(0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        step("rd_after", mi(0,0,0,0,0,0,0), mo(0,0,0,0,0,0,0));
        step("rd_ack_ignored", mi(0,0,0,0,0,1,1), mo(0,0,0,0,0,0,0));

        step("to_coin", mi(1,10,0,0,0,0,0), mo(0,0,0,0,0,0,10));
        @(negedge clk);
        drive(mi(0,0,0,0,0,0,0));
`ifdef VEND_TIMEOUT_EN
        begin
            int n = 0;
            while (!change_valid && n < 4 * TIMEOUT_CYC) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_int("to_cycles", n, TIMEOUT_CYC);
            check("to_refund", mo(0,0,0,0,1,10,10));
        end
`else
        repeat (50) @(posedge clk);
        #1;
        check("no_timeout", mo(0,0,0,0,0,0,10));
        step("to_cancel", mi(0,0,0,0,1,0,0), mo(0,0,0,0,1,10,10));
`endif
        step("to_ack", mi(0,0,0,0,0,0,1), mo(0,0,0,0,0,0,0));
        check_int("idle_credit", int'(credit), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
